// File: rtl/mprj_io_pkg.sv
// Shared encodings and reset constants for the user-project GPIO pad bank.
package mprj_io_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // Held pad defaults to tristated so a holdover during reset never drives the pad
  localparam logic HOLD_OUT_RST = 1'b0;
  localparam logic HOLD_OEB_RST = 1'b1;

  function automatic logic edge_hit(input edge_mode_e mode, input logic rise, input logic fall);
    logic [1:0] m;
    m = 2'(mode);
    return (rise & m[0]) | (fall & m[1]);
  endfunction

endpackage

// File: rtl/mprj_io_deglitch.sv
// Per-pad input synchroniser plus optional deglitch filter (enabled by MPRJ_IO_DEGLITCH_EN).
module mprj_io_deglitch #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  if (SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : g_bad_cfg
    $error("mprj_io_deglitch: SYNC_STAGES must be >= 2 and FILTER_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef MPRJ_IO_DEGLITCH_EN
  localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  // Flip only after FILTER_CYCLES consecutive cycles of disagreement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      filt  <= 1'b0;
    end else if (s == filt) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
      cnt_q <= '0;
      filt  <= s;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) filt <= 1'b0;
    else     filt <= s;
  end
`endif

endmodule

// File: rtl/mprj_io_bank.sv
// Parametrised user-project GPIO pad bank: pad cells, input conditioning, holdover, edge IRQs.
// Deglitch filtering is enabled by defining MPRJ_IO_DEGLITCH_EN.
module mprj_io_bank
  import mprj_io_pkg::*;
#(
  parameter int unsigned NUM_PADS      = 38,
  parameter int unsigned AREA1PADS     = 19,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  inout  wire  [NUM_PADS-1:0]   io,
  input  logic [NUM_PADS-1:0]   io_out,
  input  logic [NUM_PADS-1:0]   oeb,
  input  logic [NUM_PADS-1:0]   inp_dis,
  input  logic [NUM_PADS-1:0]   holdover,
  input  logic [2*NUM_PADS-1:0] edge_mode,
  input  logic [NUM_PADS-1:0]   irq_clr,
  output logic [NUM_PADS-1:0]   io_in,
  output logic [NUM_PADS-1:0]   irq_status,
  output logic                  irq
);

  if (NUM_PADS < 1 || NUM_PADS > 64 || AREA1PADS > NUM_PADS) begin : g_bad_cfg
    $error("mprj_io_bank: NUM_PADS must be 1..64 and AREA1PADS <= NUM_PADS");
  end

  logic [NUM_PADS-1:0] hold_out_q;
  logic [NUM_PADS-1:0] hold_oeb_q;
  logic [NUM_PADS-1:0] pad_out_c;
  logic [NUM_PADS-1:0] pad_oeb_c;
  logic [NUM_PADS-1:0] raw_c;
  logic [NUM_PADS-1:0] prev_q;
  logic [NUM_PADS-1:0] set_c;

  // Holdover capture: track the core while released, freeze while held
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      hold_out_q <= {NUM_PADS{HOLD_OUT_RST}};
      hold_oeb_q <= {NUM_PADS{HOLD_OEB_RST}};
    end else begin
      hold_out_q <= (hold_out_q & holdover) | (io_out & ~holdover);
      hold_oeb_q <= (hold_oeb_q & holdover) | (oeb & ~holdover);
    end
  end

  assign pad_out_c = (hold_out_q & holdover) | (io_out & ~holdover);
  assign pad_oeb_c = (hold_oeb_q & holdover) | (oeb & ~holdover);

  // fpga_gpio cells, split into the two pad areas
  for (genvar i = 0; i < AREA1PADS; i++) begin : g_area1_gpio
    assign io[i] = pad_oeb_c[i] ? 1'bz : pad_out_c[i];
  end

  for (genvar i = AREA1PADS; i < NUM_PADS; i++) begin : g_area2_gpio
    assign io[i] = pad_oeb_c[i] ? 1'bz : pad_out_c[i];
  end

  assign raw_c = io & ~inp_dis;

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_deglitch
    mprj_io_deglitch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_deglitch (
      .clk (wb_clk_i),
      .rst (wb_rst_i),
      .raw (raw_c[i]),
      .filt(io_in[i])
    );
  end

  always_comb begin
    set_c = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      set_c[i] = edge_hit(edge_mode_e'(edge_mode[2*i +: 2]),
                          io_in[i] & ~prev_q[i],
                          ~io_in[i] & prev_q[i]) & ~inp_dis[i];
    end
  end

  // Sticky status: a new edge wins over a simultaneous clear
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      prev_q     <= '0;
      irq_status <= '0;
    end else begin
      prev_q     <= io_in;
      irq_status <= (irq_status & ~irq_clr) | set_c;
    end
  end

  assign irq = |irq_status;

endmodule

// File: tb/tb_mprj_io_bank.sv
// Scoreboard bench for mprj_io_bank; adapts expected latency to MPRJ_IO_DEGLITCH_EN.
module tb_mprj_io_bank;
  import mprj_io_pkg::*;

  localparam int unsigned NUM_PADS      = 38;
  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned FILTER_CYCLES = 4;
`ifdef MPRJ_IO_DEGLITCH_EN
  localparam int LAT = SYNC_STAGES + FILTER_CYCLES;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif

  localparam int K_IO_IN = 0;
  localparam int K_STAT  = 1;
  localparam int K_IRQ   = 2;
  localparam int K_PAD   = 3;

  typedef struct {
    int    due;
    int    kind;
    int    idx;
    logic  exp;
    string tag;
  } exp_t;

  logic                  clk;
  logic                  rst;
  wire  [NUM_PADS-1:0]   io;
  logic [NUM_PADS-1:0]   io_out;
  logic [NUM_PADS-1:0]   oeb;
  logic [NUM_PADS-1:0]   inp_dis;
  logic [NUM_PADS-1:0]   holdover;
  logic [2*NUM_PADS-1:0] edge_mode;
  logic [NUM_PADS-1:0]   irq_clr;
  logic [NUM_PADS-1:0]   io_in;
  logic [NUM_PADS-1:0]   irq_status;
  logic                  irq;

  logic [NUM_PADS-1:0]   drv_en;
  logic [NUM_PADS-1:0]   drv_val;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   failures;

  mprj_io_bank #(
    .NUM_PADS     (NUM_PADS),
    .AREA1PADS    (19),
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .io        (io),
    .io_out    (io_out),
    .oeb       (oeb),
    .inp_dis   (inp_dis),
    .holdover  (holdover),
    .edge_mode (edge_mode),
    .irq_clr   (irq_clr),
    .io_in     (io_in),
    .irq_status(irq_status),
    .irq       (irq)
  );

  // Pad 0 is the DUT-driven pad; the pulldown makes a tristate read back as 0
  pulldown (io[0]);
  for (genvar k = 1; k < NUM_PADS; k++) begin : g_pad_drv
    assign io[k] = drv_en[k] ? drv_val[k] : 1'bz;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic sample(input int kind, input int idx);
    case (kind)
      K_IO_IN: return io_in[idx];
      K_STAT:  return irq_status[idx];
      K_IRQ:   return irq;
      default: return io[idx];
    endcase
  endfunction

  task automatic expect_at(input int delay, input int kind, input int idx, input logic exp,
                           input string tag);
    exp_t e;
    e.due  = cyc + delay;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = exp;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    logic obs;
    for (int n = sb.size() - 1; n >= 0; n--) begin
      if (sb[n].due == cyc) begin
        obs = sample(sb[n].kind, sb[n].idx);
        checks++;
        assert (obs === sb[n].exp) else begin
          failures++;
          $error("FAIL %s (cycle %0d) observed=%b expected=%b", sb[n].tag, cyc, obs, sb[n].exp);
        end
        sb.delete(n);
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      drain();
    end
  endtask

  task automatic check_now(input int kind, input int idx, input logic exp, input string tag);
    expect_at(0, kind, idx, exp, tag);
    #1;
    drain();
  endtask

  initial begin
    cyc       = 0;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    io_out    = '0;
    oeb       = '1;
    inp_dis   = '0;
    holdover  = '0;
    edge_mode = '0;
    irq_clr   = '0;
    drv_en    = '1;
    drv_val   = '0;

    #2;
    check_now(K_IO_IN, 3, 1'b0, "rst_io_in3");
    check_now(K_STAT, 3, 1'b0, "rst_stat3");
    check_now(K_IRQ, 0, 1'b0, "rst_irq");
    check_now(K_PAD, 0, 1'b0, "rst_pad0_tristate");
    tick(2);
    rst = 1'b0;
    tick(LAT + 2);

    // Rising pad 3 -> io_in after LAT cycles, status one cycle later
    edge_mode[2*3 +: 2] = EDGE_RISE;
    drv_val[3] = 1'b1;
    expect_at(LAT - 1, K_IO_IN, 3, 1'b0, "t1_io_in3_early");
    expect_at(LAT,     K_IO_IN, 3, 1'b1, "t1_io_in3_rise");
    expect_at(LAT,     K_STAT,  3, 1'b0, "t1_stat3_early");
    expect_at(LAT + 1, K_STAT,  3, 1'b1, "t1_stat3_set");
    expect_at(LAT + 1, K_IRQ,   0, 1'b1, "t1_irq_set");
    tick(LAT + 2);

`ifdef MPRJ_IO_DEGLITCH_EN
    // Short glitch dropped, FILTER_CYCLES pulse propagates
    edge_mode[2*5 +: 2] = EDGE_RISE;
    drv_val[5] = 1'b1;
    tick(FILTER_CYCLES - 1);
    drv_val[5] = 1'b0;
    for (int d = 1; d <= 8; d++) expect_at(d, K_IO_IN, 5, 1'b0, "t2_glitch_io_in5");
    expect_at(8, K_STAT, 5, 1'b0, "t2_glitch_stat5");
    tick(8);
    drv_val[5] = 1'b1;
    tick(FILTER_CYCLES);
    drv_val[5] = 1'b0;
    expect_at(1, K_IO_IN, 5, 1'b0, "t2_pulse_io_in5_early");
    expect_at(2, K_IO_IN, 5, 1'b1, "t2_pulse_io_in5_rise");
    expect_at(3, K_STAT,  5, 1'b1, "t2_pulse_stat5");
    expect_at(5, K_IO_IN, 5, 1'b1, "t2_pulse_io_in5_hold");
    expect_at(6, K_IO_IN, 5, 1'b0, "t2_pulse_io_in5_fall");
    tick(8);
`else
    // Without the filter a single-cycle pulse passes through after SYNC_STAGES+1
    drv_val[7] = 1'b1;
    expect_at(2, K_IO_IN, 7, 1'b0, "t6_io_in7_early");
    expect_at(3, K_IO_IN, 7, 1'b1, "t6_io_in7_pulse");
    expect_at(4, K_IO_IN, 7, 1'b0, "t6_io_in7_end");
    tick(1);
    drv_val[7] = 1'b0;
    tick(4);
`endif

    // Holdover keeps driving the captured value; release is immediate
    io_out[0] = 1'b1;
    oeb[0]    = 1'b0;
    check_now(K_PAD, 0, 1'b1, "t3_pad0_driven");
    tick(1);
    holdover[0] = 1'b1;
    tick(1);
    io_out[0] = 1'b0;
    oeb[0]    = 1'b1;
    check_now(K_PAD, 0, 1'b1, "t3_pad0_held");
    tick(1);
    check_now(K_PAD, 0, 1'b1, "t3_pad0_still_held");
    holdover[0] = 1'b0;
    check_now(K_PAD, 0, 1'b0, "t3_pad0_released");

    // Clear alone, then clear coinciding with a new edge
    irq_clr[3] = 1'b1;
    irq_clr[5] = 1'b1;
    expect_at(1, K_STAT, 3, 1'b0, "t4_clr_stat3");
    expect_at(1, K_IRQ,  0, 1'b0, "t4_clr_irq");
    tick(1);
    irq_clr = '0;
    edge_mode[2*3 +: 2] = EDGE_BOTH;
    drv_val[3] = 1'b0;
    tick(LAT);
    irq_clr[3] = 1'b1;
    expect_at(1, K_STAT, 3, 1'b1, "t4_edge_beats_clr");
    expect_at(1, K_IRQ,  0, 1'b1, "t4_edge_beats_clr_irq");
    tick(1);
    irq_clr[3] = 1'b0;
    expect_at(1, K_STAT, 3, 1'b1, "t4_stat3_sticky");
    tick(1);
    irq_clr[3] = 1'b1;
    expect_at(1, K_STAT, 3, 1'b0, "t4_clr2_stat3");
    expect_at(1, K_IRQ,  0, 1'b0, "t4_clr2_irq");
    tick(1);
    irq_clr[3] = 1'b0;

    // Reset mid-operation with status set, a filter in flight and holdover asserted
    drv_val[3] = 1'b1;
    expect_at(LAT + 1, K_STAT, 3, 1'b1, "t5_stat3_pre");
    tick(LAT + 2);
    io_out[0] = 1'b1;
    oeb[0]    = 1'b0;
    tick(1);
    holdover[0] = 1'b1;
    drv_val[5]  = 1'b1;
    tick(3);
    check_now(K_PAD, 0, 1'b1, "t5_pad0_held_pre");
    rst = 1'b1;
    check_now(K_IO_IN, 3, 1'b0, "t5_rst_io_in3");
    check_now(K_STAT,  3, 1'b0, "t5_rst_stat3");
    check_now(K_IRQ,   0, 1'b0, "t5_rst_irq");
    check_now(K_PAD,   0, 1'b0, "t5_rst_pad0_tristate");
    tick(2);
    rst = 1'b0;
    expect_at(LAT - 1, K_IO_IN, 5, 1'b0, "t5_io_in5_restart_early");
    expect_at(LAT,     K_IO_IN, 5, 1'b1, "t5_io_in5_restart");
    tick(LAT + 2);

    // Any expectation never reached is a failure
    while (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s never compared (due cycle %0d)", sb[0].tag, sb[0].due);
      void'(sb.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
